// File: rtl/q_sweep_sequencer.sv
// Setpoint sequencer for the Q control loop: walks a table of q_desired values, waits for
// convergence (with timeout) at each point, reports the cycle count, settles and resets the loop.
module q_sweep_sequencer #(
  parameter int BUS_WIDTH       = 10,
  parameter int NUM_POINTS      = 9,
  parameter int TIMEOUT_WIDTH   = 16,
  parameter int MAX_TIMEOUT     = 50000,
  parameter int SETTLE_CYCLES   = 75,
  parameter int LOOP_RST_CYCLES = 75,
  localparam int IDX_W          = $clog2(NUM_POINTS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_we_i,
  input  logic [IDX_W-1:0]         cfg_addr_i,
  input  logic [BUS_WIDTH-1:0]     cfg_data_i,
  input  logic [IDX_W:0]           n_points_i,
  input  logic                     go_i,
  input  logic                     continuous_i,
  input  logic                     abort_i,
  input  logic                     converged_i,
  output logic [BUS_WIDTH-1:0]     q_desired_o,
  output logic                     loop_rst_o,
  output logic                     loop_run_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [IDX_W-1:0]         res_idx_o,
  output logic [TIMEOUT_WIDTH-1:0] res_cycles_o,
  output logic                     res_timeout_o
);

  localparam int HOLD_MAX = (SETTLE_CYCLES > LOOP_RST_CYCLES) ? SETTLE_CYCLES : LOOP_RST_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [HOLD_W-1:0]        LRST_LAST   = HOLD_W'(LOOP_RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0]        SETTLE_LAST = HOLD_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL = TIMEOUT_WIDTH'(MAX_TIMEOUT);
  localparam logic [IDX_W:0]           NP_VAL      = (IDX_W + 1)'(NUM_POINTS);

  typedef enum logic [2:0] {
    S_IDLE, S_LRST, S_APPLY, S_WAIT, S_REPORT, S_SETTLE, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W:0]           n_eff_q, n_eff_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [TIMEOUT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [BUS_WIDTH-1:0]     q_des_q, q_des_d;
  logic [IDX_W-1:0]         res_idx_q, res_idx_d;
  logic [TIMEOUT_WIDTH-1:0] res_cycles_q, res_cycles_d;
  logic                     res_timeout_q, res_timeout_d;
  logic                     done_q, done_d;
  logic                     tbl_we;

  logic [BUS_WIDTH-1:0]     table_q [NUM_POINTS];

  logic                     go_start;
  logic                     last_point;
  logic [TIMEOUT_WIDTH-1:0] wcnt_inc;

  assign go_start   = go_i && (n_points_i != '0);
  assign last_point = ({1'b0, idx_q} + (IDX_W + 1)'(1)) >= n_eff_q;
  assign wcnt_inc   = wcnt_q + TIMEOUT_WIDTH'(1);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    n_eff_d       = n_eff_q;
    hold_d        = hold_q;
    wcnt_d        = wcnt_q;
    q_des_d       = q_des_q;
    res_idx_d     = res_idx_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;
    done_d        = 1'b0;
    tbl_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tbl_we = cfg_we_i && ({1'b0, cfg_addr_i} < NP_VAL) && !go_start;
        if (go_start) begin
          n_eff_d = (n_points_i > NP_VAL) ? NP_VAL : n_points_i;
          idx_d   = '0;
          hold_d  = '0;
          state_d = S_LRST;
        end else if (go_i) begin
          done_d = 1'b1;
        end
      end
      S_LRST: begin
        if (hold_q == LRST_LAST) begin
          hold_d  = '0;
          state_d = S_APPLY;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_APPLY: begin
        q_des_d = table_q[idx_q];
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_inc;
        // Leaving at MAX_TIMEOUT keeps the counter from ever passing it.
        if (converged_i || (wcnt_inc == TIMEOUT_VAL)) begin
          res_idx_d     = idx_q;
          res_cycles_d  = wcnt_inc;
          res_timeout_d = !converged_i;
          state_d       = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_ready_i) begin
          hold_d  = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (hold_q == SETTLE_LAST) begin
          hold_d = '0;
          if (last_point) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LRST;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_DONE: begin
        if (continuous_i) begin
          idx_d   = '0;
          hold_d  = '0;
          state_d = S_LRST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) done_d = 1'b1;

    if (abort_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      n_eff_q       <= '0;
      hold_q        <= '0;
      wcnt_q        <= '0;
      q_des_q       <= '0;
      res_idx_q     <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      n_eff_q       <= n_eff_d;
      hold_q        <= hold_d;
      wcnt_q        <= wcnt_d;
      q_des_q       <= q_des_d;
      res_idx_q     <= res_idx_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
      done_q        <= done_d;
    end
  end

  // NOTE: the table is deliberately left out of reset so a configured sweep survives rst.
  always_ff @(posedge clk_i) begin
    if (tbl_we) table_q[cfg_addr_i] <= cfg_data_i;
  end

  assign q_desired_o   = q_des_q;
  assign loop_rst_o    = (state_q == S_LRST);
  assign loop_run_o    = state_q inside {S_APPLY, S_WAIT, S_REPORT, S_SETTLE, S_DONE};
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign res_valid_o   = (state_q == S_REPORT);
  assign res_idx_o     = res_idx_q;
  assign res_cycles_o  = res_cycles_q;
  assign res_timeout_o = res_timeout_q;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Randomized bench for q_sweep_sequencer: a table model plus per-point timing rules
// (reset length, apply latency, convergence count, stall, settle) predict every observed value.
module tb_q_sweep_sequencer;

  localparam int BW   = 10;
  localparam int NP   = 9;
  localparam int TW   = 16;
  localparam int MAXT = 50;
  localparam int SET  = 4;
  localparam int LRC  = 6;
  localparam int IW   = $clog2(NP);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [BW-1:0] cfg_data = '0;
  logic [IW:0]   n_points = '0;
  logic          go = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic          converged = 1'b0;
  logic          res_ready = 1'b0;
  logic [BW-1:0] q_desired;
  logic          loop_rst, loop_run, busy, done, res_valid, res_timeout;
  logic [IW-1:0] res_idx;
  logic [TW-1:0] res_cycles;

  q_sweep_sequencer #(
    .BUS_WIDTH(BW), .NUM_POINTS(NP), .TIMEOUT_WIDTH(TW), .MAX_TIMEOUT(MAXT),
    .SETTLE_CYCLES(SET), .LOOP_RST_CYCLES(LRC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .n_points_i(n_points), .go_i(go), .continuous_i(continuous),
    .abort_i(abort), .converged_i(converged), .q_desired_o(q_desired),
    .loop_rst_o(loop_rst), .loop_run_o(loop_run), .busy_o(busy), .done_o(done),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_idx_o(res_idx),
    .res_cycles_o(res_cycles), .res_timeout_o(res_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int go_cyc = 0;
  logic [BW-1:0] model_tbl [NP];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_zero();
    check("rst_q_desired", 32'(q_desired), 0);
    check("rst_loop_rst", 32'(loop_rst), 0);
    check("rst_loop_run", 32'(loop_run), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_idx", 32'(res_idx), 0);
    check("rst_res_cycles", 32'(res_cycles), 0);
    check("rst_res_timeout", 32'(res_timeout), 0);
  endtask

  task automatic write_tbl(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = IW'(addr);
    cfg_data = BW'(data);
    tick();
    cfg_we = 1'b0;
    if (addr < NP) model_tbl[addr] = BW'(data);
  endtask

  // Entered on the first LRST cycle; returns on the cycle after SETTLE.
  task automatic run_point(input int i, input int k, input int stall, input bit poke,
                           input bit first, input bit rst_settle);
    int n;
    int exp_c;
    bit exp_to;
    exp_c  = (k < MAXT) ? k : MAXT;
    exp_to = (k > MAXT);
    n = 0;
    while (loop_rst === 1'b1 && n < LRC + 3) begin
      check("lrst_run", 32'(loop_run), 0);
      if (poke && n == 0) begin
        go       = 1'b1;
        n_points = 1;
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = ~model_tbl[0];
      end
      n++;
      tick();
      go     = 1'b0;
      cfg_we = 1'b0;
    end
    check("lrst_len", n, LRC);
    check("apply_run", 32'(loop_run), 1);
    tick();
    check("q_desired", 32'(q_desired), 32'(model_tbl[i]));
    if (first) check("go_latency", cyc - go_cyc, LRC + 2);
    n = 1;
    while (res_valid !== 1'b1 && n <= MAXT + 3) begin
      converged = (n == k);
      tick();
      n++;
    end
    converged = 1'b0;
    check("wait_len", n - 1, exp_c);
    check("res_valid", 32'(res_valid), 1);
    check("res_idx", 32'(res_idx), i);
    check("res_cycles", 32'(res_cycles), exp_c);
    check("res_timeout", 32'(res_timeout), 32'(exp_to));
    check("report_run", 32'(loop_run), 1);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 32'(res_valid), 1);
      check("stall_cycles", 32'(res_cycles), exp_c);
      check("stall_q", 32'(q_desired), 32'(model_tbl[i]));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("settle_valid", 32'(res_valid), 0);
    if (rst_settle) begin
      tick();
      rst_n = 1'b0;
      tick();
      check_zero();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 0);
      return;
    end
    n = 0;
    while (loop_rst !== 1'b1 && done !== 1'b1 && busy === 1'b1 && n < SET + 3) begin
      check("settle_run", 32'(loop_run), 1);
      n++;
      tick();
    end
    check("settle_len", n, SET);
  endtask

  task automatic start_pass(input int n_req, input bit cont, input bit cfg_with_go);
    go         = 1'b1;
    n_points   = (IW + 1)'(n_req);
    continuous = cont;
    if (cfg_with_go) begin
      cfg_we   = 1'b1;
      cfg_addr = IW'(1);
      cfg_data = ~model_tbl[1];
    end
    go_cyc = cyc;
    tick();
    go     = 1'b0;
    cfg_we = 1'b0;
    check("busy_after_go", 32'(busy), 1);
  endtask

  // kmode: 0 random, 1 converge at 10, 2 never converge, 3 converge exactly at MAX_TIMEOUT
  task automatic run_pass(input int n_req, input bit cont, input int kmode, input int stall,
                          input bit poke, input bit cfg_with_go, input bit rst_settle);
    int n_eff;
    int k;
    int st;
    int reps;
    n_eff = (n_req > NP) ? NP : n_req;
    reps  = cont ? 2 : 1;
    start_pass(n_req, cont, cfg_with_go);
    for (int rep = 0; rep < reps; rep++) begin
      if (rep == 1) continuous = 1'b0;
      for (int i = 0; i < n_eff; i++) begin
        case (kmode)
          1:       k = 10;
          2:       k = MAXT + 5;
          3:       k = MAXT;
          default: k = int'($urandom_range(MAXT + 10, 1));
        endcase
        st = (stall < 0) ? int'($urandom_range(5, 0)) : stall;
        run_point(i, k, st, poke && i == 0 && rep == 0, i == 0 && rep == 0, rst_settle);
        if (rst_settle) return;
      end
      check("done_pulse", 32'(done), 1);
      tick();
      check("done_clear", 32'(done), 0);
      if (rep == reps - 1) begin
        check("idle_busy", 32'(busy), 0);
        check("idle_run", 32'(loop_run), 0);
        check("idle_lrst", 32'(loop_rst), 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    tick();
    check_zero();
    rst_n = 1'b1;
    tick();

    write_tbl(0, 100);
    write_tbl(1, 200);
    write_tbl(2, 300);
    for (int a = 3; a < NP; a++) write_tbl(a, int'($urandom_range(1023, 0)));
    write_tbl(12, 77);

    run_pass(3, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_pass(2, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    run_pass(1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0);
    run_pass(2, 1'b0, 1, 20, 1'b0, 1'b0, 1'b0);
    run_pass(2, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);

    go       = 1'b1;
    n_points = '0;
    tick();
    go = 1'b0;
    check("n0_done", 32'(done), 1);
    check("n0_busy", 32'(busy), 0);
    check("n0_lrst", 32'(loop_rst), 0);
    tick();
    check("n0_done_clear", 32'(done), 0);
    check("n0_busy2", 32'(busy), 0);

    run_pass(15, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_pass(2, 1'b0, 0, -1, 1'b1, 1'b1, 1'b0);

    start_pass(3, 1'b0, 1'b0);
    repeat (LRC + 4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_run", 32'(loop_run), 0);
    check("abort_lrst", 32'(loop_rst), 0);
    check("abort_valid", 32'(res_valid), 0);
    check("abort_done", 32'(done), 0);
    tick();
    check("abort_done2", 32'(done), 0);

    run_pass(2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    run_pass(3, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      write_tbl(int'($urandom_range(NP - 1, 0)), int'($urandom_range(1023, 0)));
      write_tbl(int'($urandom_range(NP - 1, 0)), int'($urandom_range(1023, 0)));
      run_pass(int'($urandom_range(NP, 1)), 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
